fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address fetched first after reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000, word handed to decode in a squashed slot.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_address  output  32  instruction memory address (current PC).
REQ-006 i_data_mem  input  32  instruction memory data; synchronous memory, word for the address presented in cycle N valid in cycle N+1.
REQ-007 stall  input  1  hazard hold: freeze PC and the decode-side outputs.
REQ-008 Pc_cmd_id  input  1  unconditional jump resolved in decode.
REQ-009 pc_in_ID  input  32  decode jump target.
REQ-010 Pc_cmd_ex  input  1  taken branch/jump resolved in execute.
REQ-011 pc_in_EX  input  32  execute target.
REQ-012 i_data_read  output  32  instruction word to decode.
REQ-013 PC_ID  output  32  address of the word on i_data_read.
REQ-014 valid_ID  output  1  i_data_read is a real fetched instruction (0 = bubble).
REQ-015 redirect_count  output  16  number of redirect cycles since reset.

Function
REQ-016 i_address SHALL equal the PC register combinationally.
REQ-017 Next PC priority SHALL be: Pc_cmd_ex -> pc_in_EX; else Pc_cmd_id -> pc_in_ID; else stall -> PC; else PC+4.
REQ-018 Redirect targets SHALL have bits [1:0] forced to 0; PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-019 A redirect cycle (Pc_cmd_ex or Pc_cmd_id high) SHALL override stall.
REQ-020 Advance cycle (no stall, or redirect): PC_ID SHALL capture PC and i_data_read SHALL show i_data_mem in the following cycle.
REQ-021 Redirect cycle: following cycle SHALL present i_data_read = NOP_WORD, valid_ID = 0, PC_ID = address of squashed word; no delay slot.
REQ-022 Stall cycle without redirect: PC, PC_ID, valid_ID SHALL hold; the word on i_data_read SHALL be captured into a hold register on the first stall cycle and presented unchanged for the whole stall, independent of i_data_mem.
REQ-023 The first cycle after a stall ends SHALL still present the held word; the next sequential word SHALL follow one cycle later (memory re-read of held PC).
REQ-024 A squashed (NOP) slot that is stalled SHALL remain NOP with valid_ID = 0.
REQ-025 redirect_count SHALL increment by 1 per redirect cycle (simultaneous ex+id = 1) and saturate at 16'hFFFF.
REQ-026 Latency: address issued in cycle N appears on i_data_read/PC_ID in cycle N+1 absent stall.

Reset
REQ-027 While reset_n = 0: PC = RESET_PC, PC_ID = RESET_PC, i_data_read = NOP_WORD, valid_ID = 0, redirect_count = 0, hold/squash state cleared, immediately (asynchronous).
REQ-028 First rising edge after release SHALL advance PC to RESET_PC+4 and set valid_ID = 1 with the word at RESET_PC.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all pending state.

Verification
REQ-030 Release reset, no stall: i_address 0,4,8,...; PC_ID lags by one cycle; valid_ID 0 then 1.
REQ-031 PC=0x10, Pc_cmd_id=1, pc_in_ID=0x100: next i_address 0x100; next slot NOP, valid_ID 0; then word@0x100 with PC_ID 0x100; redirect_count 1.
REQ-032 Same cycle Pc_cmd_ex=1 pc_in_EX=0x200 and Pc_cmd_id=1 pc_in_ID=0x100: i_address 0x200, count +1 only.
REQ-033 stall=1 for 3 cycles at PC=0x20 with i_data_mem toggling: i_address 0x20, PC_ID 0x1C, i_data_read constant; after release, resume at 0x20 per REQ-023.
REQ-034 stall=1 with Pc_cmd_ex=1 pc_in_EX=0x103: i_address 0x100 next cycle, following slot NOP.
REQ-035 Force 65536 redirects: count holds 16'hFFFF; assert reset_n=0 mid-stall: all outputs to reset values without a clock edge.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, redirect/stall arbitration and
// the decode-side slot (word, PC, valid) with a stall hold register.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] i_address,
    input  logic [31:0] i_data_mem,
    input  logic        stall,
    input  logic        Pc_cmd_id,
    input  logic [31:0] pc_in_ID,
    input  logic        Pc_cmd_ex,
    input  logic [31:0] pc_in_EX,
    output logic [31:0] i_data_read,
    output logic [31:0] PC_ID,
    output logic        valid_ID,
    output logic [15:0] redirect_count
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic [31:0] pc_id_q;
    logic [31:0] hold_word;
    logic        hold_vld;
    logic        squash;
    logic        valid_q;
    logic [15:0] count_q;
    logic        redirect;
    logic        advance;

    assign redirect = Pc_cmd_ex | Pc_cmd_id;
    assign advance  = redirect | ~stall;
    assign target   = Pc_cmd_ex ? pc_in_EX : pc_in_ID;

    always_comb begin
        pc_next = pc + 32'd4;
        if (redirect)
            pc_next = {target[31:2], 2'b00};
        else if (stall)
            pc_next = pc;
    end

    // A squashed slot wins over the hold register so a stalled bubble stays a bubble.
    always_comb begin
        i_data_read = i_data_mem;
        if (squash)
            i_data_read = NOP_WORD;
        else if (hold_vld)
            i_data_read = hold_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            pc_id_q   <= RESET_PC;
            valid_q   <= 1'b0;
            squash    <= 1'b1;
            hold_vld  <= 1'b0;
            hold_word <= NOP_WORD;
            count_q   <= 16'd0;
        end else begin
            pc <= pc_next;
            if (advance) begin
                pc_id_q  <= pc;
                valid_q  <= ~redirect;
                squash   <= redirect;
                hold_vld <= 1'b0;
            end else if (!hold_vld) begin
                hold_vld  <= 1'b1;
                hold_word <= i_data_read;
            end
            if (redirect && count_q != 16'hFFFF)
                count_q <= count_q + 16'd1;
        end
    end

    assign i_address      = pc;
    assign PC_ID          = pc_id_q;
    assign valid_ID       = valid_q;
    assign redirect_count = count_q;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] i_address;
    logic [31:0] i_data_mem;
    logic        stall = 1'b0;
    logic        Pc_cmd_id = 1'b0;
    logic [31:0] pc_in_ID = '0;
    logic        Pc_cmd_ex = 1'b0;
    logic [31:0] pc_in_EX = '0;
    logic [31:0] i_data_read;
    logic [31:0] PC_ID;
    logic        valid_ID;
    logic [15:0] redirect_count;

    logic [31:0] mem_q = '0;
    logic [31:0] scr = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pcid;
        logic        vld;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    fetch #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_address(i_address),
        .i_data_mem(i_data_mem),
        .stall(stall),
        .Pc_cmd_id(Pc_cmd_id),
        .pc_in_ID(pc_in_ID),
        .Pc_cmd_ex(Pc_cmd_ex),
        .pc_in_EX(pc_in_EX),
        .i_data_read(i_data_read),
        .PC_ID(PC_ID),
        .valid_ID(valid_ID),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hC0DE0000 ^ a;
    endfunction

    // Synchronous instruction memory; scr corrupts the bus to prove holding.
    always @(posedge clk) mem_q <= w(i_address);
    assign i_data_mem = mem_q ^ scr;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            exp_t a;
            e = sb.pop_front();
            a = '{i_address, PC_ID, valid_ID, i_data_read, redirect_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL slot chk%0d: got addr=%h pcid=%h v=%b data=%h cnt=%h need addr=%h pcid=%h v=%b data=%h cnt=%h",
                         checks, a.addr, a.pcid, a.vld, a.data, a.cnt,
                         e.addr, e.pcid, e.vld, e.data, e.cnt);
            end
        end
    end

    task automatic push(input logic [31:0] ea, input logic [31:0] ep,
                        input logic ev, input logic [31:0] ed,
                        input logic [15:0] ec);
        exp_t e;
        e = '{ea, ep, ev, ed, ec};
        sb.push_back(e);
    endtask

    task automatic cyc(input logic st, input logic ci, input logic [31:0] ti,
                       input logic ce, input logic [31:0] te,
                       input logic [31:0] sc,
                       input logic [31:0] ea, input logic [31:0] ep,
                       input logic ev, input logic [31:0] ed,
                       input logic [15:0] ec);
        @(posedge clk);
        #1;
        stall = st;
        Pc_cmd_id = ci;
        pc_in_ID = ti;
        Pc_cmd_ex = ce;
        pc_in_EX = te;
        scr = sc;
        push(ea, ep, ev, ed, ec);
    endtask

    initial begin
        // held in reset
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, NOP, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(32'h0, 32'h0, 0, NOP, 16'd0);
        // sequential run
        cyc(0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, w(32'h0), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 32'h8, 32'h4, 1, w(32'h4), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 32'hC, 32'h8, 1, w(32'h8), 16'd0);
        // decode jump to 0x100
        cyc(0, 1, 32'h100, 0, 0, 0, 32'h10, 32'hC, 1, w(32'hC), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 32'h100, 32'h10, 0, NOP, 16'd1);
        // simultaneous ex and id, ex wins
        cyc(0, 1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100, 1, w(32'h100), 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 32'h200, 32'h104, 0, NOP, 16'd2);
        cyc(0, 1, 32'h1C, 0, 0, 0, 32'h204, 32'h200, 1, w(32'h200), 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 32'h1C, 32'h204, 0, NOP, 16'd3);
        // three-cycle stall at PC=0x20 with a toggling memory bus
        cyc(1, 0, 0, 0, 0, 0, 32'h20, 32'h1C, 1, w(32'h1C), 16'd3);
        cyc(1, 0, 0, 0, 0, 32'hFFFF0000, 32'h20, 32'h1C, 1, w(32'h1C), 16'd3);
        cyc(1, 0, 0, 0, 0, 32'h0000FFFF, 32'h20, 32'h1C, 1, w(32'h1C), 16'd3);
        cyc(0, 0, 0, 0, 0, 32'h12345678, 32'h20, 32'h1C, 1, w(32'h1C), 16'd3);
        // stall overridden by unaligned execute redirect
        cyc(1, 0, 0, 1, 32'h103, 0, 32'h24, 32'h20, 1, w(32'h20), 16'd3);
        // stalled bubble stays a bubble
        cyc(1, 0, 0, 0, 0, 0, 32'h100, 32'h24, 0, NOP, 16'd4);
        cyc(0, 0, 0, 0, 0, 0, 32'h100, 32'h24, 0, NOP, 16'd4);
        // address wrap at the top of memory
        cyc(0, 1, 32'hFFFFFFFA, 0, 0, 0, 32'h104, 32'h100, 1, w(32'h100), 16'd4);
        cyc(0, 0, 0, 0, 0, 0, 32'hFFFFFFF8, 32'h104, 0, NOP, 16'd5);
        cyc(0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFF8, 1, w(32'hFFFFFFF8), 16'd5);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFC, 1, w(32'hFFFFFFFC), 16'd5);
        cyc(0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, w(32'h0), 16'd5);
        // saturate the redirect counter
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
            #1;
            Pc_cmd_id = 1'b1;
            pc_in_ID = 32'h40;
        end
        cyc(0, 0, 0, 0, 0, 0, 32'h40, 32'h40, 0, NOP, 16'hFFFF);
        cyc(1, 0, 0, 0, 0, 0, 32'h44, 32'h40, 1, w(32'h40), 16'hFFFF);
        // reset lands mid-stall, between clock edges
        @(posedge clk);
        #1;
        scr = 32'h5555AAAA;
        push(32'h0, 32'h0, 0, NOP, 16'd0);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        stall = 1'b0;
        scr = '0;
        push(32'h0, 32'h0, 0, NOP, 16'd0);
        #2;
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, w(32'h0), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 32'h8, 32'h4, 1, w(32'h4), 16'd0);
        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending need 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
